// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the Famicom CPU-bus initiator.
// Holds the access-state enum, default M2 timing and bus widths.
package cart_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC_LOW  = 2'd1,
    ACC_HIGH = 2'd2
  } acc_state_t;

  localparam int DEF_HALF_PERIOD   = 6;
  localparam int DEF_SAMPLE_OFFSET = 5;

  localparam int CPU_ADDR_W = 15;
  localparam int DATA_W     = 8;

endpackage

// File: rtl/cpu_bus_master_if.sv
// Host request/response port plus cartridge-side CPU bus for cpu_bus_master.
// Handshake: a request is taken on a clk where req_valid && req_ready; req_ready is
// only offered on the last M2-high clk, and the request must hold stable until taken.
interface cpu_bus_master_if;
  import cart_bus_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [15:0]           req_addr;
  logic                  req_rw;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;

  logic                  m2;
  logic                  romsel;
  logic                  cpu_rw;
  logic [CPU_ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_data_out;
  logic                  cpu_data_oe;
  logic [DATA_W-1:0]     cpu_data_in;
  logic                  irq_n;
  logic                  irq_active;
  logic [31:0]           m2_cycles;

  modport master (
    input  req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
    output req_ready, resp_valid, resp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, irq_active, m2_cycles
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
    input  req_ready, resp_valid, resp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, irq_active, m2_cycles
  );

endinterface

// File: rtl/m2_phase_gen.sv
// Free-running M2 generator: phase counter, M2 level, end-of-phase strobes
// and a count of M2 rising edges.
module m2_phase_gen
  import cart_bus_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int PH_W        = $clog2(HALF_PERIOD)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            m2,
  output logic [PH_W-1:0] phase,
  output logic            last_low,
  output logic            last_high,
  output logic [31:0]     m2_cycles
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= '0;
      m2        <= 1'b0;
      m2_cycles <= '0;
    end else if (phase == PH_LAST) begin
      phase <= '0;
      m2    <= ~m2;
      if (!m2) m2_cycles <= m2_cycles + 32'd1;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign last_low  = ~m2 & (phase == PH_LAST);
  assign last_high =  m2 & (phase == PH_LAST);

endmodule

// File: rtl/cpu_bus_master.sv
// Famicom CPU-bus initiator: turns host requests into 6502-style read/write
// cycles locked to a free-running M2, and returns the synchronised cart irq.
module cpu_bus_master
  import cart_bus_pkg::*;
#(
  parameter int HALF_PERIOD   = DEF_HALF_PERIOD,
  parameter int SAMPLE_OFFSET = DEF_SAMPLE_OFFSET
) (
  input  logic       clk,
  input  logic       reset,
  cpu_bus_master_if.master bus,
  output acc_state_t state_dbg
);

  localparam int PH_W = (HALF_PERIOD < 2) ? 1 : $clog2(HALF_PERIOD);
  localparam logic [PH_W-1:0] SAMPLE_PH = PH_W'(SAMPLE_OFFSET);

  generate
    if (HALF_PERIOD < 2) begin : g_bad_half_period
      $error("cpu_bus_master: HALF_PERIOD must be 2 or more");
    end
    if (SAMPLE_OFFSET < 0 || SAMPLE_OFFSET >= HALF_PERIOD) begin : g_bad_sample_offset
      $error("cpu_bus_master: SAMPLE_OFFSET must lie in 0..HALF_PERIOD-1");
    end
  endgenerate

  logic            m2;
  logic [PH_W-1:0] phase;
  logic            last_low;
  logic            last_high;
  logic [31:0]     m2_cycles;

  m2_phase_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .PH_W        (PH_W)
  ) u_phase (
    .clk       (clk),
    .reset     (reset),
    .m2        (m2),
    .phase     (phase),
    .last_low  (last_low),
    .last_high (last_high),
    .m2_cycles (m2_cycles)
  );

  acc_state_t        state_q, state_d;
  logic [15:0]       addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              req_ready_c;
  logic              resp_valid_c;
  logic              romsel_c;
  logic              cpu_rw_c;
  logic              oe_c;
  logic              sample_now;
  logic              irq_s1, irq_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_ready_c && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        rw_q    <= bus.req_rw;
        wdata_q <= bus.req_wdata;
      end
      if (sample_now) rdata_q <= bus.cpu_data_in;
    end
  end

  assign sample_now = (state_q == ACC_HIGH) && m2 && rw_q && (phase == SAMPLE_PH);

  always_comb begin
    state_d      = state_q;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    romsel_c     = 1'b1;
    cpu_rw_c     = 1'b1;
    oe_c         = 1'b0;
    case (state_q)
      IDLE: begin
        if (last_high) begin
          req_ready_c = 1'b1;
          if (bus.req_valid) state_d = ACC_LOW;
        end
      end
      ACC_LOW: begin
        cpu_rw_c = rw_q;
        if (last_low) state_d = ACC_HIGH;
      end
      ACC_HIGH: begin
        cpu_rw_c = rw_q;
        romsel_c = ~addr_q[15];
        oe_c     = ~rw_q;
        // The response clk doubles as the next acceptance slot, so accesses chain without a gap.
        if (last_high) begin
          resp_valid_c = 1'b1;
          req_ready_c  = 1'b1;
          state_d      = bus.req_valid ? ACC_LOW : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1 <= 1'b1;
      irq_s2 <= 1'b1;
    end else begin
      irq_s1 <= bus.irq_n;
      irq_s2 <= irq_s1;
    end
  end

  // When the sample point is the response clk itself, the register has not loaded yet,
  // so the live bus value is forwarded instead.
  assign bus.resp_rdata   = (resp_valid_c && rw_q) ?
                            (sample_now ? bus.cpu_data_in : rdata_q) : '0;
  assign bus.req_ready    = req_ready_c;
  assign bus.resp_valid   = resp_valid_c;
  assign bus.m2           = m2;
  assign bus.romsel       = romsel_c;
  assign bus.cpu_rw       = cpu_rw_c;
  assign bus.cpu_addr     = addr_q[CPU_ADDR_W-1:0];
  assign bus.cpu_data_out = wdata_q;
  assign bus.cpu_data_oe  = oe_c;
  assign bus.irq_active   = ~irq_s2;
  assign bus.m2_cycles    = m2_cycles;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master at default timing: free-running M2, read/write cycles,
// back-to-back chaining, reset abort and irq synchronisation.
module tb_cpu_bus_master;
  import cart_bus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  acc_state_t state_dbg;

  cpu_bus_master_if bus();

  cpu_bus_master #(
    .HALF_PERIOD   (6),
    .SAMPLE_OFFSET (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [7:0] mon_exp;
  int         mon_cyc;

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        vec_cnt++;
        if (bus.resp_rdata !== mon_exp) begin
          err_cnt++;
          $display("FAIL resp_rdata: got %h, required %h", bus.resp_rdata, mon_exp);
        end
        vec_cnt++;
        if (cyc !== mon_cyc) begin
          err_cnt++;
          $display("FAIL resp_latency: resp at cycle %0d, required cycle %0d", cyc, mon_cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [15:0] addr, input logic rw, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input bit keep, output int acc_cyc);
    int n;
    bus.req_addr  = addr;
    bus.req_rw    = rw;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    acc_cyc = -1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (bus.req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL accept_timeout: req_ready=%b after %0d clks, required 1", bus.req_ready, n);
      bus.req_valid = 1'b0;
    end else begin
      acc_cyc = cyc;
      exp_q.push_back(exp_rd);
      exp_cyc_q.push_back(cyc + 12);
      @(posedge clk);
      #1;
      if (!keep) bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_rw      = 1'b1;
    bus.req_wdata   = '0;
    bus.cpu_data_in = '0;
    bus.irq_n       = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({bus.m2, bus.romsel, bus.cpu_rw, bus.cpu_data_oe, bus.req_ready, bus.resp_valid,
         bus.irq_active} !== 7'b0110000) begin
      err_cnt++;
      $display("FAIL reset_ctrl: m2/romsel/rw/oe/ready/resp/irq=%b, required 0110000",
               {bus.m2, bus.romsel, bus.cpu_rw, bus.cpu_data_oe, bus.req_ready,
                bus.resp_valid, bus.irq_active});
    end
    vec_cnt++;
    if ({bus.cpu_addr, bus.cpu_data_out, bus.resp_rdata} !== 31'd0) begin
      err_cnt++;
      $display("FAIL reset_data: addr=%h dout=%h rdata=%h, required all 0",
               bus.cpu_addr, bus.cpu_data_out, bus.resp_rdata);
    end
    vec_cnt++;
    if (bus.m2_cycles !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_m2_cycles: got %0d, required 0", bus.m2_cycles);
    end
    vec_cnt++;
    if (state_dbg !== IDLE) begin
      err_cnt++;
      $display("FAIL reset_state: got %0d, required IDLE", state_dbg);
    end
  endtask

  task automatic test_free_run();
    logic exp_m2;
    reset = 1'b0;
    for (int i = 0; i <= 120; i++) begin
      exp_m2 = ((i / 6) % 2) == 1;
      vec_cnt++;
      if (bus.m2 !== exp_m2) begin
        err_cnt++;
        $display("FAIL free_m2: clk %0d m2=%b, required %b", i, bus.m2, exp_m2);
      end
      vec_cnt++;
      if ({bus.romsel, bus.cpu_rw} !== 2'b11) begin
        err_cnt++;
        $display("FAIL free_idle_bus: clk %0d romsel/rw=%b, required 11", i,
                 {bus.romsel, bus.cpu_rw});
      end
      if (i == 120) begin
        vec_cnt++;
        if (bus.m2_cycles !== 32'd10) begin
          err_cnt++;
          $display("FAIL free_m2_cycles: got %0d, required 10", bus.m2_cycles);
        end
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_read();
    int acc;
    bus.cpu_data_in = 8'h3C;
    do_req(16'h8000, 1'b1, 8'h00, 8'hA5, 1'b0, acc);
    // Only high clk 5 carries the true data; anything else on the bus is junk.
    for (int j = 1; j <= 12; j++) begin
      bus.cpu_data_in = (j == 12) ? 8'hA5 : 8'h3C;
      @(negedge clk);
      vec_cnt++;
      if (bus.romsel !== (j <= 6)) begin
        err_cnt++;
        $display("FAIL read_romsel: clk %0d romsel=%b, required %b", j, bus.romsel, (j <= 6));
      end
      vec_cnt++;
      if ({bus.cpu_rw, bus.cpu_data_oe, bus.cpu_addr} !== {1'b1, 1'b0, 15'h0000}) begin
        err_cnt++;
        $display("FAIL read_bus: clk %0d rw=%b oe=%b addr=%h, required 1 0 0000",
                 j, bus.cpu_rw, bus.cpu_data_oe, bus.cpu_addr);
      end
      if (j < 12) begin
        @(posedge clk);
        #1;
      end
    end
    wait_resp();
  endtask

  task automatic test_write();
    int acc;
    do_req(16'h6000, 1'b0, 8'h5A, 8'h00, 1'b0, acc);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      vec_cnt++;
      if ({bus.cpu_rw, bus.romsel, bus.cpu_addr} !== {1'b0, 1'b1, 15'h6000}) begin
        err_cnt++;
        $display("FAIL write_bus: clk %0d rw=%b romsel=%b addr=%h, required 0 1 6000",
                 j, bus.cpu_rw, bus.romsel, bus.cpu_addr);
      end
      vec_cnt++;
      if (bus.cpu_data_oe !== (j > 6)) begin
        err_cnt++;
        $display("FAIL write_oe: clk %0d oe=%b, required %b", j, bus.cpu_data_oe, (j > 6));
      end
      if (j > 6) begin
        vec_cnt++;
        if (bus.cpu_data_out !== 8'h5A) begin
          err_cnt++;
          $display("FAIL write_data: clk %0d dout=%h, required 5a", j, bus.cpu_data_out);
        end
      end
    end
    wait_resp();
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    bus.cpu_data_in = 8'h96;
    do_req(16'hC000, 1'b1, 8'h00, 8'h96, 1'b1, a1);
    do_req(16'h8001, 1'b0, 8'h77, 8'h00, 1'b0, a2);
    vec_cnt++;
    if (a2 - a1 !== 12) begin
      err_cnt++;
      $display("FAIL b2b_gap: acceptance gap %0d clks, required 12", a2 - a1);
    end
    @(negedge clk);
    vec_cnt++;
    if ({bus.cpu_rw, bus.cpu_addr} !== {1'b0, 15'h0001}) begin
      err_cnt++;
      $display("FAIL b2b_second_bus: rw=%b addr=%h, required 0 0001", bus.cpu_rw, bus.cpu_addr);
    end
    wait_resp();
  endtask

  task automatic test_reset_abort();
    int acc;
    do_req(16'h8002, 1'b0, 8'hAB, 8'h00, 1'b0, acc);
    repeat (7) @(posedge clk);
    #2;
    vec_cnt++;
    if ({bus.cpu_data_oe, bus.m2, bus.romsel} !== 3'b110) begin
      err_cnt++;
      $display("FAIL abort_pre: oe/m2/romsel=%b, required 110",
               {bus.cpu_data_oe, bus.m2, bus.romsel});
    end
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    vec_cnt++;
    if ({bus.cpu_data_oe, bus.m2, bus.romsel} !== 3'b001) begin
      err_cnt++;
      $display("FAIL abort_immediate: oe/m2/romsel=%b, required 001",
               {bus.cpu_data_oe, bus.m2, bus.romsel});
    end
    vec_cnt++;
    if (state_dbg !== IDLE) begin
      err_cnt++;
      $display("FAIL abort_state: got %0d, required IDLE", state_dbg);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    bus.cpu_data_in = 8'h42;
    do_req(16'h8003, 1'b1, 8'h00, 8'h42, 1'b0, acc);
    wait_resp();
  endtask

  task automatic test_irq();
    @(posedge clk);
    #1 bus.irq_n = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      vec_cnt++;
      if (bus.irq_active !== (n >= 2)) begin
        err_cnt++;
        $display("FAIL irq_rise: clk %0d irq_active=%b, required %b", n, bus.irq_active, (n >= 2));
      end
    end
    bus.irq_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      vec_cnt++;
      if (bus.irq_active !== (n < 2)) begin
        err_cnt++;
        $display("FAIL irq_fall: clk %0d irq_active=%b, required %b", n, bus.irq_active, (n < 2));
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_abort();
    test_irq();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Synchronous Famicom CPU-bus initiator; the counterpart of the cartridge-side mapper logic, which responds to m2, romsel, cpu_rw and cpu_addr.
- Generates a free-running M2 clock and CPU read/write cycles from a simple host request/response interface.
- Used in the team's dumper/flash-programmer and in hardware-in-loop benches to drive the cartridge exactly as a 6502 bus would.
- Also returns the cartridge irq line, synchronised, and counts M2 cycles for mapper IRQ-counter checks.

Parameters:
- HALF_PERIOD, 6: clk cycles per M2 half-phase; legal range is 2 or more.
- SAMPLE_OFFSET, 5: clk index within the M2-high phase at which read data is captured; legal range is 0 to HALF_PERIOD-1.

Ports:
- clk input 1: block clock.
- reset input 1: asynchronous, active-high reset.
- req_valid input 1: host request present.
- req_ready output 1: one-clk acceptance slot.
- req_addr input 16: CPU address.
- req_rw input 1: 1 = read, 0 = write.
- req_wdata input 8: write data.
- resp_valid output 1: one-clk pulse when a read or write completes.
- resp_rdata output 8: captured read data; 0 for writes.
- m2 output 1: generated M2.
- romsel output 1: active-low, asserted for addr[15]=1 during M2 high.
- cpu_rw output 1: bus R/W.
- cpu_addr output 15: bus A14..A0.
- cpu_data_out output 8: write data to the bus.
- cpu_data_oe output 1: enable for the bus data driver.
- cpu_data_in input 8: bus data from the cartridge.
- irq_n input 1: cartridge irq, active-low, asynchronous.
- irq_active output 1: synchronised, active-high irq.
- m2_cycles output 32: count of M2 rising edges.

Behaviour:
- Reset values: m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0, cpu_data_oe=0, req_ready=0, resp_valid=0, resp_rdata=0, irq_active=0, m2_cycles=0, phase counter=0, state=IDLE.
- Reset is asynchronous. Assertion mid-access aborts the access immediately, and cpu_data_oe drops in the same instant. No resp_valid is issued for the aborted request.
- M2 generation:
  - M2 always free-runs, including while no request is pending, so mapper counters keep ticking.
  - Each half-phase is HALF_PERIOD clks long, so the full period is 2*HALF_PERIOD clks.
  - A phase counter runs 0..HALF_PERIOD-1 and wraps. m2 toggles on the wrap.
  - m2_cycles increments on every low-to-high transition and wraps modulo 2^32.
- States: IDLE, ACC_LOW, ACC_HIGH.
- Acceptance slot:
  - req_ready=1 only on the last clk of an M2-high phase, when the state is IDLE or ACC_HIGH.
  - req_valid and req_ready both high means the request is accepted; the state moves to ACC_LOW on the next clk.
  - No request accepted means the state becomes or stays IDLE.
- ACC_LOW (M2 low):
  - cpu_addr = req_addr[14:0], latched on acceptance.
  - cpu_rw = req_rw.
  - romsel=1.
  - cpu_data_oe=0.
- ACC_HIGH (M2 high):
  - romsel = ~addr[15].
  - Write:
    - cpu_data_oe=1 and cpu_data_out=wdata for the whole high phase.
  - Read:
    - cpu_data_in is registered at phase counter = SAMPLE_OFFSET.
- End of ACC_HIGH, on the last high clk:
  - resp_valid pulses for one clk, with resp_rdata valid.
  - This is the same clk as the next acceptance slot, which allows back-to-back accesses with no idle M2 cycle.
- Latency: resp_valid is asserted 2*HALF_PERIOD clks after the acceptance clk.
- On the M2 falling edge: romsel returns to 1, cpu_data_oe returns to 0, and cpu_rw returns to 1 unless the next access is a write.
- IDLE: cpu_rw=1, romsel=1, cpu_data_oe=0, and cpu_addr holds its last value.
- irq_n passes through a 2-flop synchroniser; irq_active = ~synced. Latency is 2 clks, and level is followed in both directions.
- Host rule: a request must stay stable while req_valid=1 and it is not yet accepted.
- Parameter checks: an elaboration-time error is raised if HALF_PERIOD<2 or SAMPLE_OFFSET>=HALF_PERIOD.

Decomposition:
- Shared package cart_bus_pkg holds:
  - the state enum (IDLE, ACC_LOW, ACC_HIGH);
  - the default timing constants;
  - the bus width constants (CPU_ADDR_W=15, DATA_W=8).
- One sub-module, m2_phase_gen, owns the phase counter, m2, the last-clk-of-phase strobes and m2_cycles.
- The access FSM and the irq synchroniser stay in the top module.

Test Plan (all with defaults):
- Release reset, no requests → m2 toggles every 6 clks; m2_cycles=10 after 120 clks; romsel stays 1 and cpu_rw stays 1 throughout.
- Read of 0x8000, cart drives 0xA5 → romsel=0 only during the M2-high phase; data sampled at high clk 5; resp_valid 12 clks after acceptance with resp_rdata=0xA5.
- Write of 0x5A to 0x6000 → cpu_rw=0 from the start of the low phase; romsel stays 1; cpu_data_oe=1 only during M2 high, with cpu_data_out=0x5A.
- Back-to-back requests (read 0xC000, then write 0x8001), req_valid held high → accepted on consecutive acceptance slots; no idle M2 cycle between them; two resp_valid pulses 12 clks apart.
- Assert reset during the ACC_HIGH phase of a write → cpu_data_oe=0, m2=0, romsel=1 immediately; no resp_valid; a normal read completes after release.
- irq_n toggled low for 30 clks → irq_active rises 2 clks after the falling edge and falls 2 clks after irq_n returns high.
